// File: rtl/glb_fill_ctrl_if.sv
// Stream-in and GLB write-port bundle for glb_fill_ctrl.
// master = stream source / GLB side, slave = the fill controller.
interface glb_fill_ctrl_if #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10
);
    logic                     in_valid;
    logic [DATA_BITWIDTH-1:0] in_data;
    logic                     in_ready;
    logic                     write_en_wght;
    logic [ADDR_BITWIDTH-1:0] w_addr_wght;
    logic [DATA_BITWIDTH-1:0] w_data_wght;
    logic                     write_en_iact;
    logic [ADDR_BITWIDTH-1:0] w_addr_iact;
    logic [DATA_BITWIDTH-1:0] w_data_iact;

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  write_en_wght, w_addr_wght, w_data_wght,
        input  write_en_iact, w_addr_iact, w_data_iact
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output write_en_wght, w_addr_wght, w_data_wght,
        output write_en_iact, w_addr_iact, w_data_iact
    );
endinterface

// File: rtl/glb_fill_ctrl.sv
// GLB fill controller: streams words into the weight GLB, then the iact GLB.
// Optional running XOR checksum output enabled by GLB_FILL_CHKSUM_EN.
module glb_fill_ctrl #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_BITWIDTH-1:0] wght_base,
    input  logic [ADDR_BITWIDTH-1:0] wght_len,
    input  logic [ADDR_BITWIDTH-1:0] iact_base,
    input  logic [ADDR_BITWIDTH-1:0] iact_len,
    glb_fill_ctrl_if.slave           bus,
    output logic                     busy,
    output logic                     done
`ifdef GLB_FILL_CHKSUM_EN
    ,
    output logic [DATA_BITWIDTH-1:0] chksum
`endif
);
    localparam logic [ADDR_BITWIDTH-1:0] ONE = ADDR_BITWIDTH'(1);

    typedef enum logic [1:0] {IDLE, LD_WGHT, LD_IACT, DONE} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] wbase_q, wbase_d, wlen_q, wlen_d;
    logic [ADDR_BITWIDTH-1:0] ibase_q, ibase_d, ilen_q, ilen_d;
    logic [ADDR_BITWIDTH-1:0] cnt_q, cnt_d;
    logic                     we_w_q, we_w_d, we_i_q, we_i_d;
    logic [ADDR_BITWIDTH-1:0] addr_w_q, addr_w_d, addr_i_q, addr_i_d;
    logic [DATA_BITWIDTH-1:0] data_w_q, data_w_d, data_i_q, data_i_d;
    logic                     ready, hs;

    assign ready = (state_q == LD_WGHT) || (state_q == LD_IACT);
    assign hs    = bus.in_valid && ready;

    always_comb begin
        state_d  = state_q;
        wbase_d  = wbase_q;
        wlen_d   = wlen_q;
        ibase_d  = ibase_q;
        ilen_d   = ilen_q;
        cnt_d    = cnt_q;
        we_w_d   = 1'b0;
        we_i_d   = 1'b0;
        addr_w_d = addr_w_q;
        data_w_d = data_w_q;
        addr_i_d = addr_i_q;
        data_i_d = data_i_q;

        // Write side follows the handshake regardless of abort.
        if (hs && state_q == LD_WGHT) begin
            we_w_d   = 1'b1;
            addr_w_d = wbase_q + cnt_q;
            data_w_d = bus.in_data;
        end
        if (hs && state_q == LD_IACT) begin
            we_i_d   = 1'b1;
            addr_i_d = ibase_q + cnt_q;
            data_i_d = bus.in_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    wbase_d = wght_base;
                    wlen_d  = wght_len;
                    ibase_d = iact_base;
                    ilen_d  = iact_len;
                    cnt_d   = '0;
                    if (wght_len != '0)      state_d = LD_WGHT;
                    else if (iact_len != '0) state_d = LD_IACT;
                    else                     state_d = DONE;
                end
            end
            LD_WGHT: begin
                if (hs) begin
                    if (cnt_q == wlen_q - ONE) begin
                        cnt_d   = '0;
                        state_d = (ilen_q != '0) ? LD_IACT : DONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            LD_IACT: begin
                if (hs) begin
                    if (cnt_q == ilen_q - ONE) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wbase_q  <= '0;
            wlen_q   <= '0;
            ibase_q  <= '0;
            ilen_q   <= '0;
            cnt_q    <= '0;
            we_w_q   <= 1'b0;
            we_i_q   <= 1'b0;
            addr_w_q <= '0;
            data_w_q <= '0;
            addr_i_q <= '0;
            data_i_q <= '0;
        end else begin
            state_q  <= state_d;
            wbase_q  <= wbase_d;
            wlen_q   <= wlen_d;
            ibase_q  <= ibase_d;
            ilen_q   <= ilen_d;
            cnt_q    <= cnt_d;
            we_w_q   <= we_w_d;
            we_i_q   <= we_i_d;
            addr_w_q <= addr_w_d;
            data_w_q <= data_w_d;
            addr_i_q <= addr_i_d;
            data_i_q <= data_i_d;
        end
    end

`ifdef GLB_FILL_CHKSUM_EN
    logic [DATA_BITWIDTH-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == IDLE && start)        chk_d = '0;
        else if (abort && state_q != IDLE)   chk_d = '0;
        else if (hs)                         chk_d = chk_q ^ bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) chk_q <= '0;
        else        chk_q <= chk_d;
    end

    assign chksum = chk_q;
`endif

    assign bus.in_ready      = ready;
    assign bus.write_en_wght = we_w_q;
    assign bus.w_addr_wght   = addr_w_q;
    assign bus.w_data_wght   = data_w_q;
    assign bus.write_en_iact = we_i_q;
    assign bus.w_addr_iact   = addr_i_q;
    assign bus.w_data_iact   = data_i_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE) && !abort;
endmodule
